// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        DRAIN    = 2'b10
    } state_t;

    localparam logic [1:0] FWD_REG = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    // True when a pipeline stage will write a non-x0 register matching rs.
    function automatic logic writes_reg(input logic valid, input logic we,
                                        input logic [4:0] rd, input logic [4:0] rs);
        return valid & we & (rd != 5'd0) & (rd == rs);
    endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// Operand forwarding select for one EX source register (MEM beats WB).
module hazard_fwd_unit
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0] ex_rs,
    input  logic       mem_valid,
    input  logic       mem_reg_we,
    input  logic [4:0] mem_rd,
    input  logic       wb_valid,
    input  logic       wb_reg_we,
    input  logic [4:0] wb_rd,
    output logic [1:0] fwd_sel
);

    always_comb begin
        fwd_sel = FWD_REG;
        if (writes_reg(mem_valid, mem_reg_we, mem_rd, ex_rs))
            fwd_sel = FWD_MEM;
        else if (writes_reg(wb_valid, wb_reg_we, wb_rd, ex_rs))
            fwd_sel = FWD_WB;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait stalls with timeout, branch flush,
// load-use stall and forwarding. Perf counters built only with HAZARD_CTRL_PERF_EN.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_valid,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_reg_we,
    input  logic             ex_load,
    input  logic             ex_brn_tkn,
    input  logic             mem_valid,
    input  logic [4:0]       mem_rd,
    input  logic             mem_reg_we,
    input  logic             mem_req,
    input  logic             mem_ack,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    input  logic             wb_reg_we,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             id_ex_stall,
    output logic             ex_mem_stall,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_bubble,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYC + 1);

    state_t            state, state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_stall_req;
    logic              load_use;

    assign mem_stall_req = mem_valid & mem_req & ~mem_ack;
    assign load_use = ex_valid & ex_load & ex_reg_we & (ex_rd != 5'd0) & id_valid &
                      ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == MEM_WAIT)
                wait_cnt <= wait_cnt + WAIT_W'(1);
            else
                wait_cnt <= '0;
        end
    end

    // Reset low forces state to RUN asynchronously; the outer if also masks
    // the combinational branch/load-use paths so every control is 0 in reset.
    always_comb begin
        state_next    = state;
        pc_stall      = 1'b0;
        if_id_stall   = 1'b0;
        id_ex_stall   = 1'b0;
        ex_mem_stall  = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        mem_wb_bubble = 1'b0;
        mem_timeout   = 1'b0;
        if (reset) begin
            case (state)
                RUN: begin
                    if (mem_stall_req) begin
                        {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall} = '1;
                        mem_wb_bubble = 1'b1;
                        state_next    = MEM_WAIT;
                    end else if (ex_valid && ex_brn_tkn) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (load_use) begin
                        pc_stall    = 1'b1;
                        if_id_stall = 1'b1;
                        id_ex_flush = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ack) begin
                        state_next = RUN;
                    end else begin
                        {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall} = '1;
                        mem_wb_bubble = 1'b1;
                        if (wait_cnt == WAIT_W'(TIMEOUT_CYC - 1)) begin
                            mem_timeout = 1'b1;
                            state_next  = DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if_id_flush   = 1'b1;
                    id_ex_flush   = 1'b1;
                    mem_wb_bubble = 1'b1;
                    state_next    = RUN;
                end
                default: state_next = RUN;
            endcase
        end
    end

    hazard_fwd_unit u_fwd_a (
        .ex_rs      (ex_rs1),
        .mem_valid  (mem_valid),
        .mem_reg_we (mem_reg_we),
        .mem_rd     (mem_rd),
        .wb_valid   (wb_valid),
        .wb_reg_we  (wb_reg_we),
        .wb_rd      (wb_rd),
        .fwd_sel    (fwd_a_sel)
    );

    hazard_fwd_unit u_fwd_b (
        .ex_rs      (ex_rs2),
        .mem_valid  (mem_valid),
        .mem_reg_we (mem_reg_we),
        .mem_rd     (mem_rd),
        .wb_valid   (wb_valid),
        .wb_reg_we  (wb_reg_we),
        .wb_rd      (wb_rd),
        .fwd_sel    (fwd_b_sel)
    );

`ifdef HAZARD_CTRL_PERF_EN
    logic stall_any;
    assign stall_any = pc_stall | if_id_stall | id_ex_stall | ex_mem_stall;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_any && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (if_id_flush && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl (TIMEOUT_CYC=4).
module tb_hazard_ctrl;

    localparam int unsigned CNT_W = 32;
`ifdef HAZARD_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush, id_ex_flush, mem_wb_bubble, mem_timeout}
    localparam logic [7:0] CTL_IDLE  = 8'b0000_0000;
    localparam logic [7:0] CTL_LU    = 8'b1100_0100;
    localparam logic [7:0] CTL_BR    = 8'b0000_1100;
    localparam logic [7:0] CTL_MSTL  = 8'b1111_0010;
    localparam logic [7:0] CTL_TMO   = 8'b1111_0011;
    localparam logic [7:0] CTL_DRAIN = 8'b0000_1110;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic id_valid, id_use_rs1, id_use_rs2;
    logic [4:0] id_rs1, id_rs2;
    logic ex_valid, ex_reg_we, ex_load, ex_brn_tkn;
    logic [4:0] ex_rs1, ex_rs2, ex_rd;
    logic mem_valid, mem_reg_we, mem_req, mem_ack;
    logic [4:0] mem_rd;
    logic wb_valid, wb_reg_we;
    logic [4:0] wb_rd;
    logic pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
    logic if_id_flush, id_ex_flush, mem_wb_bubble, mem_timeout;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [7:0] ctl;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 clock = ~clock;

    assign ctl = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
                  if_id_flush, id_ex_flush, mem_wb_bubble, mem_timeout};

    hazard_ctrl #(.TIMEOUT_CYC(4), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_valid(ex_valid), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_reg_we(ex_reg_we), .ex_load(ex_load), .ex_brn_tkn(ex_brn_tkn),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_reg_we(mem_reg_we),
        .mem_req(mem_req), .mem_ack(mem_ack),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_reg_we(wb_reg_we),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall),
        .id_ex_stall(id_ex_stall), .ex_mem_stall(ex_mem_stall),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .mem_wb_bubble(mem_wb_bubble),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .mem_timeout(mem_timeout),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_valid = 0; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0;
        ex_reg_we = 0; ex_load = 0; ex_brn_tkn = 0;
        mem_valid = 0; mem_rd = 0; mem_reg_we = 0; mem_req = 0; mem_ack = 0;
        wb_valid = 0; wb_rd = 0; wb_reg_we = 0;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic sample();
        @(negedge clock);
    endtask

    task automatic reset_pulse();
        reset = 1'b0;
        sample();
        check("rst_ctl", {24'd0, ctl}, {24'd0, CTL_IDLE});
        check("rst_stall_cnt", stall_cnt, 32'd0);
        check("rst_flush_cnt", flush_cnt, 32'd0);
        next_cycle();
        reset = 1'b1;
        next_cycle();
    endtask

    initial begin
        clear_inputs();
        #1 reset = 1'b0;

        // During reset: controls masked, forwarding still live.
        ex_valid = 1; ex_brn_tkn = 1; ex_rs1 = 5'd3;
        mem_valid = 1; mem_reg_we = 1; mem_rd = 5'd3; mem_req = 1;
        sample();
        check("in_reset_ctl", {24'd0, ctl}, {24'd0, CTL_IDLE});
        check("in_reset_fwd_a", {30'd0, fwd_a_sel}, 32'd1);
        check("in_reset_stall_cnt", stall_cnt, 32'd0);
        check("in_reset_flush_cnt", flush_cnt, 32'd0);
        next_cycle();
        clear_inputs();
        reset = 1'b1;
        next_cycle();
        sample();
        check("idle_ctl", {24'd0, ctl}, {24'd0, CTL_IDLE});

        // Load-use on x5, then load moves to MEM (bubble in EX), then dependent in EX.
        next_cycle();
        ex_valid = 1; ex_load = 1; ex_reg_we = 1; ex_rd = 5'd5;
        id_valid = 1; id_use_rs1 = 1; id_rs1 = 5'd5;
        sample();
        check("lu_ctl", {24'd0, ctl}, {24'd0, CTL_LU});
        next_cycle();
        clear_inputs();
        id_valid = 1; id_use_rs1 = 1; id_rs1 = 5'd5;
        mem_valid = 1; mem_reg_we = 1; mem_rd = 5'd5;
        sample();
        check("lu_after_ctl", {24'd0, ctl}, {24'd0, CTL_IDLE});
        next_cycle();
        clear_inputs();
        ex_valid = 1; ex_rs1 = 5'd5;
        wb_valid = 1; wb_reg_we = 1; wb_rd = 5'd5;
        sample();
        check("lu_dep_fwd_a", {30'd0, fwd_a_sel}, 32'd2);
        check("lu_dep_ctl", {24'd0, ctl}, {24'd0, CTL_IDLE});

        // x0 never stalls or forwards.
        next_cycle();
        clear_inputs();
        ex_valid = 1; ex_load = 1; ex_reg_we = 1; ex_rd = 5'd0;
        id_valid = 1; id_use_rs1 = 1; id_rs1 = 5'd0;
        mem_valid = 1; mem_reg_we = 1; mem_rd = 5'd0; ex_rs1 = 5'd0;
        sample();
        check("x0_ctl", {24'd0, ctl}, {24'd0, CTL_IDLE});
        check("x0_fwd_a", {30'd0, fwd_a_sel}, 32'd0);

        // Forwarding priority: MEM over WB, WB when only WB matches.
        next_cycle();
        clear_inputs();
        mem_valid = 1; mem_reg_we = 1; mem_rd = 5'd7;
        wb_valid = 1; wb_reg_we = 1; wb_rd = 5'd7;
        ex_rs2 = 5'd7;
        sample();
        check("fwd_b_mem", {30'd0, fwd_b_sel}, 32'd1);
        next_cycle();
        wb_rd = 5'd8; ex_rs1 = 5'd8;
        sample();
        check("fwd_a_wb", {30'd0, fwd_a_sel}, 32'd2);
        check("fwd_b_mem2", {30'd0, fwd_b_sel}, 32'd1);

        // Branch alone, then branch plus load-use.
        next_cycle();
        clear_inputs();
        ex_valid = 1; ex_brn_tkn = 1;
        sample();
        check("br_ctl", {24'd0, ctl}, {24'd0, CTL_BR});
        next_cycle();
        ex_load = 1; ex_reg_we = 1; ex_rd = 5'd9;
        id_valid = 1; id_use_rs2 = 1; id_rs2 = 5'd9;
        sample();
        check("br_lu_ctl", {24'd0, ctl}, {24'd0, CTL_BR});

        // Memory stall: 4 stall cycles, ack on the 5th; held branch waits for RUN.
        next_cycle();
        clear_inputs();
        reset_pulse();
        mem_valid = 1; mem_req = 1; ex_valid = 1; ex_brn_tkn = 1;
        for (int i = 0; i < 4; i++) begin
            sample();
            check($sformatf("mstall_ctl%0d", i), {24'd0, ctl}, {24'd0, CTL_MSTL});
            next_cycle();
        end
        mem_ack = 1;
        sample();
        check("mstall_ack_ctl", {24'd0, ctl}, {24'd0, CTL_IDLE});
        check("mstall_stall_cnt", stall_cnt, PERF ? 32'd4 : 32'd0);
        next_cycle();
        mem_req = 0; mem_ack = 0;
        sample();
        check("mstall_br_ctl", {24'd0, ctl}, {24'd0, CTL_BR});
        next_cycle();
        clear_inputs();
        sample();
        check("mstall_flush_cnt", flush_cnt, PERF ? 32'd1 : 32'd0);

        // Timeout: pulse on 4th wait cycle, one DRAIN, then RUN.
        next_cycle();
        mem_valid = 1; mem_req = 1;
        for (int i = 0; i < 4; i++) begin
            sample();
            check($sformatf("tmo_wait_ctl%0d", i), {24'd0, ctl}, {24'd0, CTL_MSTL});
            next_cycle();
        end
        sample();
        check("tmo_pulse_ctl", {24'd0, ctl}, {24'd0, CTL_TMO});
        next_cycle();
        clear_inputs();
        sample();
        check("tmo_drain_ctl", {24'd0, ctl}, {24'd0, CTL_DRAIN});
        next_cycle();
        sample();
        check("tmo_run_ctl", {24'd0, ctl}, {24'd0, CTL_IDLE});

        // Reset mid-MEM_WAIT: everything 0, no timeout even past the limit.
        next_cycle();
        mem_valid = 1; mem_req = 1;
        sample();
        check("rmw_run_ctl", {24'd0, ctl}, {24'd0, CTL_MSTL});
        next_cycle();
        sample();
        check("rmw_wait_ctl", {24'd0, ctl}, {24'd0, CTL_MSTL});
        next_cycle();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            sample();
            check($sformatf("rmw_rst_ctl%0d", i), {24'd0, ctl}, {24'd0, CTL_IDLE});
            next_cycle();
        end
        check("rmw_stall_cnt", stall_cnt, 32'd0);
        clear_inputs();
        reset = 1'b1;
        sample();
        check("rmw_after_ctl", {24'd0, ctl}, {24'd0, CTL_IDLE});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
- TIMEOUT_CYC, 255, maximum MEM_WAIT cycles before abort.
- CNT_W, 32, performance counter width.
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
- clock in 1: sole clock, rising edge.
- reset in 1: asynchronous, active-low reset.
- id_valid in 1, id_rs1 in 5, id_rs2 in 5, id_use_rs1 in 1, id_use_rs2 in 1: decode-stage operands.
- ex_valid in 1, ex_rs1 in 5, ex_rs2 in 5, ex_rd in 5, ex_reg_we in 1, ex_load in 1, ex_brn_tkn in 1: execute stage.
- mem_valid in 1, mem_rd in 5, mem_reg_we in 1, mem_req in 1, mem_ack in 1: memory stage and data-memory handshake.
- wb_valid in 1, wb_rd in 5, wb_reg_we in 1: writeback stage.
- pc_stall out 1, if_id_stall out 1, id_ex_stall out 1, ex_mem_stall out 1: hold-register enables.
- if_id_flush out 1, id_ex_flush out 1, mem_wb_bubble out 1: squash controls.
- fwd_a_sel out 2, fwd_b_sel out 2: EX operand source (0 regfile, 1 MEM, 2 WB).
- mem_timeout out 1: one-cycle abort pulse.
- stall_cnt out CNT_W, flush_cnt out CNT_W: performance counters.

Function
REQ-003 SHALL implement the FSM states RUN, MEM_WAIT and DRAIN, encoded per hazard_ctrl_pkg.
REQ-004 In RUN, mem_valid&mem_req&!mem_ack SHALL assert all four stall outputs and mem_wb_bubble in the same cycle; next state SHALL be MEM_WAIT.
REQ-005 In MEM_WAIT, all four stalls and mem_wb_bubble SHALL stay asserted while mem_ack=0; in the cycle mem_ack=1 they SHALL deassert and next state SHALL be RUN.
REQ-006 The wait counter SHALL clear on MEM_WAIT entry and increment each MEM_WAIT cycle; on reaching TIMEOUT_CYC without ack, mem_timeout SHALL pulse for 1 cycle and next state SHALL be DRAIN.
REQ-007 DRAIN SHALL last exactly 1 cycle, asserting if_id_flush, id_ex_flush and mem_wb_bubble with stalls deasserted, then go to RUN.
REQ-008 In RUN with no memory stall, ex_valid&ex_brn_tkn SHALL assert if_id_flush and id_ex_flush in the same cycle.
REQ-009 In RUN, a load-use hazard SHALL assert pc_stall, if_id_stall and id_ex_flush for exactly 1 cycle. A hazard is ex_valid&ex_load&ex_reg_we&ex_rd!=0&id_valid with (id_use_rs1&id_rs1==ex_rd) or (id_use_rs2&id_rs2==ex_rd).
REQ-010 Priority SHALL be memory stall > branch flush > load-use stall; branch plus load-use in the same cycle SHALL produce flush only.
REQ-011 A branch asserted during MEM_WAIT SHALL be ignored until the state returns to RUN; ex_brn_tkn stays held by the frozen EX stage.
REQ-012 fwd_a_sel SHALL be 1 if mem_valid&mem_reg_we&mem_rd!=0&mem_rd==ex_rs1. Otherwise it SHALL be 2 if the same condition holds for the WB fields. Otherwise it SHALL be 0. fwd_b_sel SHALL be identical using ex_rs2.
REQ-013 Forward selects SHALL be combinational and valid in every state.
REQ-014 Register x0 SHALL never cause a stall or a forward.

Reset
REQ-015 reset low SHALL immediately force state RUN, wait counter 0, stall_cnt 0, flush_cnt 0 and mem_timeout 0.
REQ-016 Reset asserted mid-MEM_WAIT SHALL abort the wait with no mem_timeout pulse.
REQ-017 During reset, all stall, flush and bubble outputs SHALL be 0, and fwd selects SHALL follow REQ-012.

Configuration
REQ-018 With HAZARD_CTRL_PERF_EN defined:
- stall_cnt SHALL increment every cycle any stall output is 1.
- flush_cnt SHALL increment every cycle if_id_flush is 1.
- Both counters SHALL saturate at all-ones.
REQ-019 Without HAZARD_CTRL_PERF_EN, stall_cnt and flush_cnt SHALL be constant 0 and the counter flops SHALL not be instantiated.

Structure
REQ-020 hazard_ctrl_pkg SHALL hold the state typedef and the FWD_REG=0, FWD_MEM=1 and FWD_WB=2 constants.
REQ-021 Forwarding comparators SHALL be a sub-module hazard_fwd_unit, instantiated once per operand.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Load x5 in EX, ID uses rs1=x5 -> exactly one cycle of pc_stall=if_id_stall=id_ex_flush=1, then fwd_a_sel=2 on the dependent instruction.
- Load with ex_rd=0 and ID rs1=0 -> no stall.
- MEM ALU write x7 and WB write x7, ex_rs2=7 -> fwd_b_sel=1; MEM write x7, WB write x8, ex_rs1=8 -> fwd_a_sel=2.
- mem_req held, ack after 3 cycles -> 4 cycles of full stall; with HAZARD_CTRL_PERF_EN, stall_cnt=4.
- TIMEOUT_CYC=4 and no ack -> mem_timeout pulse on the 4th wait cycle, then one DRAIN cycle with both flushes, then RUN.
- Branch and load-use in the same cycle -> flushes only, no stall; reset low mid-MEM_WAIT -> all outputs 0 and no timeout pulse.
